// File: rtl/cbd_stream.sv
// Streaming centered-binomial sampler: PRF bytes in, signed eta-CBD coeffs out.
// Ports: i_clk/i_rst, i_start+i_eta, i_data/i_valid/o_ready, o_coeffs/o_valid/i_ready/o_last, o_busy, o_err.
module cbd_stream #(
   parameter int IN_BYTES = 4,
   parameter int NCOEF    = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [1:0]              i_eta,
   input  logic [8*IN_BYTES-1:0]   i_data,
   input  logic                    i_valid,
   output logic                    o_ready,
   output logic [3*NCOEF-1:0]      o_coeffs,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_last,
   output logic                    o_busy,
   output logic                    o_err
);

   localparam int IN_W   = 8*IN_BYTES;
   localparam int BUF_W  = IN_W + 6*NCOEF;
   localparam int CW     = $clog2(BUF_W+1);
   localparam int NBEATS = 256/NCOEF;

   typedef enum logic {IDLE, RUN} state_e;

   state_e             state_q, state_d;
   logic               eta3_q, eta3_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [CW-1:0]      bitcnt_q, bitcnt_d;
   logic [8:0]         words_q, words_d;
   logic [8:0]         beat_q, beat_d;
   logic               err_q, err_d;

   logic               start_ok, push, pop, run;
   logic [CW-1:0]      pop_bits, base;
   logic [BUF_W-1:0]   shifted;
   logic [3*NCOEF-1:0] dec;

   assign start_ok = i_start && (i_eta == 2'd2 || i_eta == 2'd3);
   assign pop_bits = eta3_q ? CW'(6*NCOEF) : CW'(4*NCOEF);
   assign push     = i_valid && o_ready;
   assign pop      = o_valid && i_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         eta3_q   <= 1'b0;
         buf_q    <= '0;
         bitcnt_q <= '0;
         words_q  <= '0;
         beat_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         eta3_q   <= eta3_d;
         buf_q    <= buf_d;
         bitcnt_q <= bitcnt_d;
         words_q  <= words_d;
         beat_q   <= beat_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start_ok) state_d = RUN;
         RUN:  if (pop && o_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Each coefficient is popcount(low eta bits) - popcount(high eta bits).
   always_comb begin
      logic [5:0] s;
      logic [2:0] a, b;
      dec = '0;
      for (int k = 0; k < NCOEF; k++) begin
         if (eta3_q) begin
            s = buf_q[6*k +: 6];
            a = {2'b0, s[0]} + {2'b0, s[1]} + {2'b0, s[2]};
            b = {2'b0, s[3]} + {2'b0, s[4]} + {2'b0, s[5]};
         end else begin
            s = {2'b00, buf_q[4*k +: 4]};
            a = {2'b0, s[0]} + {2'b0, s[1]};
            b = {2'b0, s[2]} + {2'b0, s[3]};
         end
         dec[3*k +: 3] = a - b;
      end
   end

   always_comb begin
      run      = (state_q == RUN);
      o_busy   = run;
      o_ready  = run && (words_q != '0) && (bitcnt_q <= CW'(BUF_W-IN_W));
      o_valid  = run && (bitcnt_q >= pop_bits);
      o_last   = o_valid && (beat_q == 9'(NBEATS-1));
      o_coeffs = o_valid ? dec : '0;
      o_err    = err_q;
   end

   // A pop shifts the consumed bits out first; the new word lands above what remains.
   always_comb begin
      eta3_d   = eta3_q;
      buf_d    = buf_q;
      bitcnt_d = bitcnt_q;
      words_d  = words_q;
      beat_d   = beat_q;
      err_d    = (state_q == IDLE) && i_start && !start_ok;
      shifted  = pop ? (buf_q >> pop_bits) : buf_q;
      base     = pop ? (bitcnt_q - pop_bits) : bitcnt_q;
      if (state_q == IDLE) begin
         if (start_ok) begin
            eta3_d   = i_eta[0];
            buf_d    = '0;
            bitcnt_d = '0;
            beat_d   = '0;
            words_d  = (i_eta == 2'd3) ? 9'(192/IN_BYTES) : 9'(128/IN_BYTES);
         end
      end else begin
         if (push) begin
            buf_d    = shifted | (BUF_W'(i_data) << base);
            bitcnt_d = base + CW'(IN_W);
            words_d  = words_q - 9'd1;
         end else begin
            buf_d    = shifted;
            bitcnt_d = base;
         end
         if (pop) beat_d = beat_q + 9'd1;
      end
   end

endmodule

// File: tb/tb_cbd_stream.sv
// Directed bench for cbd_stream: constant-byte patterns, random stalls,
// error pulses, restart-in-run and mid-polynomial reset.
module tb_cbd_stream;

   localparam int IB = 4;
   localparam int NC = 4;
   localparam int NB = 256/NC;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [1:0]        eta;
   logic [8*IB-1:0]   data;
   logic              ivalid;
   logic              oready;
   logic [3*NC-1:0]   coeffs;
   logic              ovalid;
   logic              iready;
   logic              last;
   logic              busy;
   logic              err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]      mem [0:255];
   logic [3*NC-1:0] got [0:255];
   logic            gl  [0:255];

   cbd_stream #(.IN_BYTES(IB), .NCOEF(NC)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_eta(eta),
      .i_data(data), .i_valid(ivalid), .o_ready(oready),
      .o_coeffs(coeffs), .o_valid(ovalid), .i_ready(iready),
      .o_last(last), .o_busy(busy), .o_err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [3*NC-1:0] model_beat(int e, int beat);
      logic [3*NC-1:0] r;
      int a, b, base, j;
      r = '0;
      for (int k = 0; k < NC; k++) begin
         base = 2*e*(beat*NC + k);
         a = 0;
         b = 0;
         for (int t = 0; t < e; t++) begin
            j = base + t;
            a += int'(mem[j/8][j%8]);
            j = base + e + t;
            b += int'(mem[j/8][j%8]);
         end
         r[3*k +: 3] = 3'(a - b);
      end
      return r;
   endfunction

   function automatic logic [8*IB-1:0] word_at(int w);
      logic [8*IB-1:0] r;
      r = '0;
      for (int b = 0; b < IB; b++)
         if (w*IB + b < 256) r[8*b +: 8] = mem[w*IB + b];
      return r;
   endfunction

   task automatic fill(input int mode, input logic [7:0] v);
      for (int i = 0; i < 256; i++)
         mem[i] = (mode == 0) ? v : 8'($urandom);
   endtask

   task automatic start_poly(input logic [1:0] e);
      @(negedge clk);
      start = 1'b1;
      eta   = e;
      @(negedge clk);
      start = 1'b0;
      eta   = 2'd2;
   endtask

   task automatic drive_poly(input bit stall, input int start_at,
                             input int abort_beat,
                             output int nbeats, output int nwords);
      int  cyc;
      bit  done, iv, ir, prev_st, prev_last;
      logic [3*NC-1:0] prev_c;
      cyc = 0; done = 0; prev_st = 0; prev_last = 0; prev_c = '0;
      nbeats = 0; nwords = 0;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         if (abort_beat >= 0 && nbeats == abort_beat) begin
            ivalid = 1'b0;
            iready = 1'b0;
            return;
         end
         if (prev_st) begin
            n_cmp++;
            if (ovalid !== 1'b1 || coeffs !== prev_c || last !== prev_last) begin
               n_bad++;
               $display("FAIL stall_hold: v=%b c=%h l=%b need v=1 c=%h l=%b",
                        ovalid, coeffs, last, prev_c, prev_last);
            end
         end
         iv = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         ir = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         ivalid = iv;
         iready = ir;
         data   = word_at(nwords);
         start  = (cyc == start_at);
         eta    = (cyc == start_at) ? 2'd3 : 2'd2;
         if (ovalid && ir) begin
            got[nbeats] = coeffs;
            gl[nbeats]  = last;
            nbeats++;
            if (last) done = 1;
         end
         if (iv && oready) nwords++;
         prev_st   = ovalid && !ir;
         prev_c    = coeffs;
         prev_last = last;
         cyc++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: beats=%0d need %0d", nbeats, NB);
      end
      @(negedge clk);
      ivalid = 1'b0;
      iready = 1'b0;
      start  = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({oready, ovalid, last, busy, err, coeffs} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b need 0",
                  {oready, ovalid, last, busy, err, coeffs});
      end
      rst = 1'b0;
   endtask

   task automatic test_const(input string nm, input logic [1:0] e,
                             input logic [7:0] v, input logic [3*NC-1:0] exp,
                             input int exp_words);
      int nb, nw, bad;
      fill(0, v);
      start_poly(e);
      drive_poly(1'b0, -1, -1, nb, nw);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_busy_fall: got %b need 0", nm, busy);
      end
      n_cmp++;
      if (nb !== NB || nw !== exp_words) begin
         n_bad++;
         $display("FAIL %s_counts: beats=%0d words=%0d need %0d %0d",
                  nm, nb, nw, NB, exp_words);
      end
      bad = 0;
      for (int n = 0; n < nb; n++) begin
         n_cmp++;
         if (got[n] !== exp || gl[n] !== (n == NB-1)) begin
            n_bad++;
            if (bad < 4)
               $display("FAIL %s_beat%0d: got %h last=%b need %h last=%b",
                        nm, n, got[n], gl[n], exp, (n == NB-1));
            bad++;
         end
      end
   endtask

   task automatic check_model(input string nm, input int e, input int nb);
      logic [3*NC-1:0] m;
      int bad;
      bad = 0;
      n_cmp++;
      if (nb !== NB) begin
         n_bad++;
         $display("FAIL %s_nbeats: got %0d need %0d", nm, nb, NB);
      end
      for (int n = 0; n < nb; n++) begin
         m = model_beat(e, n);
         n_cmp++;
         if (got[n] !== m || gl[n] !== (n == NB-1)) begin
            n_bad++;
            if (bad < 4)
               $display("FAIL %s_beat%0d: got %h last=%b need %h last=%b",
                        nm, n, got[n], gl[n], m, (n == NB-1));
            bad++;
         end
      end
   endtask

   task automatic test_random(input logic [1:0] e);
      int nb, nw;
      fill(1, 8'h00);
      start_poly(e);
      drive_poly(1'b1, -1, -1, nb, nw);
      check_model(e == 2'd3 ? "rand_eta3" : "rand_eta2", int'(e), nb);
      n_cmp++;
      if (nw !== 64*int'(e)/IB) begin
         n_bad++;
         $display("FAIL rand_words: got %0d need %0d", nw, 64*int'(e)/IB);
      end
   endtask

   task automatic test_err(input logic [1:0] e);
      @(negedge clk);
      start = 1'b1;
      eta   = e;
      @(negedge clk);
      start = 1'b0;
      eta   = 2'd2;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL err_pulse_eta%0d: err=%b busy=%b need 1 0", e, err, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear_eta%0d: err=%b busy=%b need 0 0", e, err, busy);
      end
   endtask

   task automatic test_start_in_run;
      int nb, nw;
      fill(1, 8'h00);
      start_poly(2'd2);
      drive_poly(1'b0, 10, -1, nb, nw);
      check_model("start_in_run", 2, nb);
   endtask

   task automatic test_rst_mid;
      int nb, nw;
      fill(1, 8'h00);
      start_poly(2'd2);
      drive_poly(1'b0, -1, 20, nb, nw);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({oready, ovalid, last, busy, err, coeffs} !== '0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs: got %b need 0",
                  {oready, ovalid, last, busy, err, coeffs});
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (ovalid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_quiet: v=%b busy=%b need 0 0", ovalid, busy);
         end
      end
      fill(1, 8'h00);
      start_poly(2'd2);
      drive_poly(1'b0, -1, -1, nb, nw);
      check_model("rst_mid_restart", 2, nb);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; eta = 2'd2;
      data = '0; ivalid = 1'b0; iready = 1'b0;
      test_reset;
      test_const("zero", 2'd2, 8'h00, 12'h000, 32);
      test_const("b03", 2'd2, 8'h03, 12'h082, 32);
      test_const("b0c", 2'd2, 8'h0C, 12'h186, 32);
      test_const("b07_eta3", 2'd3, 8'h07, 12'h3BB, 48);
      test_random(2'd2);
      test_random(2'd3);
      test_err(2'd1);
      test_err(2'd0);
      test_start_in_run;
      test_rst_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cbd_stream.md
Name: cbd_stream

Overview:
Streaming, parametrised centered-binomial-distribution sampler for Kyber noise polynomials. It accepts PRF output bytes a word at a time over a valid/ready input and emits NCOEF signed coefficients per beat over a valid/ready output. Each polynomial has 256 coefficients. The eta mode (2 or 3) is selected per polynomial at start. It is the sequential replacement for the flat 1536-bit combinational cbd between the SHAKE/PRF stage and NTT input buffering.

Parameters:
IN_BYTES, 4, input word width in bytes; legal values 1, 2, 4, 8.
NCOEF, 4, coefficients per output beat; legal values 1, 2, 4, 8.
BUF_W, 8*IN_BYTES+6*NCOEF, bit-buffer width (localparam).

Ports:
i_clk  in  1  clock; all state on rising edge.
i_rst  in  1  synchronous active-high reset.
i_start  in  1  one-cycle pulse; begins one polynomial.
i_eta  in  2  mode, sampled with i_start; 2'd2 or 2'd3.
i_data  in  8*IN_BYTES  input bytes; byte 0 at i_data[7:0].
i_valid  in  1  i_data valid.
o_ready  out  1  block accepts i_data this cycle.
o_coeffs  out  3*NCOEF  coefficients, 3-bit two's complement; coefficient k of beat at [3k+2:3k].
o_valid  out  1  o_coeffs valid.
i_ready  in  1  downstream accepts o_coeffs.
o_last  out  1  high with o_valid on the beat carrying coefficient 255.
o_busy  out  1  polynomial in progress.
o_err  out  1  one-cycle pulse when i_start is rejected because i_eta is not 2 or 3.

Behaviour:
- Reset values: o_ready=0, o_valid=0, o_last=0, o_busy=0, o_err=0, o_coeffs=0. Bit buffer, counters and eta are cleared. FSM goes to IDLE.
- FSM IDLE:
  - i_start with i_eta in {2,3}: latch eta, clear counters, go to RUN next cycle.
  - i_start with any other eta: o_err=1 next cycle, stay IDLE.
- FSM RUN:
  - i_start is ignored.
  - Go to IDLE on the cycle after the o_last beat is accepted. o_busy=1 throughout RUN.
- Bit order: stream bit j is byte j/8, bit j%8, bytes in arrival order. Accepted words append above the bits already in the buffer; pops remove from the LSB end.
- Coefficient n uses stream bits [2*eta*n, 2*eta*n+2*eta-1]:
  - a = popcount of the low eta bits.
  - b = popcount of the high eta bits.
  - coeff = a-b, range -eta..eta, sign-extended into 3 bits.
- Input handshake: transfer when i_valid && o_ready.
  - o_ready = RUN && words_left>0 && bitcnt <= BUF_W-8*IN_BYTES.
  - o_ready depends on registers only, not on i_ready.
  - words_left starts at 64*eta/IN_BYTES (eta=2, IN_BYTES=4: 32 words; eta=3: 48 words).
  - No words are accepted beyond this count.
- Output handshake: transfer when o_valid && i_ready.
  - o_valid = RUN && bitcnt >= 2*eta*NCOEF.
  - o_coeffs is decoded combinationally from buffer bits [2*eta*NCOEF-1:0].
  - While o_valid=1 and i_ready=0, o_coeffs and o_last hold stable.
- Latency: a beat becomes valid in the cycle after the edge on which its last needed bit is accepted.
- Throughput: one beat per cycle whenever input sustains it. NCOEF=4 emits 64 beats per polynomial.
- Simultaneous push and pop in one cycle: bitcnt' = bitcnt + 8*IN_BYTES - 2*eta*NCOEF. The new word is placed after the shift.
- No leftover bits: total bits always equal coefficients used. At o_last acceptance bitcnt is 0.
- Reset mid-operation: buffer is flushed, FSM returns to IDLE, no further o_valid until a new i_start.

Test Plan:
- Zero input, eta=2, IN_BYTES=4, NCOEF=4: 32 words of 0x00000000 -> 64 beats of o_coeffs=12'h000, o_last only on beat 63, o_busy falls the cycle after.
- Bytes 0x03 and 0x0C, eta=2:
  - All bytes 0x03 -> coefficients alternate 2,0 (3'b010, 3'b000).
  - All bytes 0x0C -> coefficients alternate -2,0 (3'b110, 3'b000).
- All bytes 0x07, eta=3 -> coeff0=3 (3'b011), coeff1=-1 (3'b111).
  - 48 words accepted; o_ready=0 after word 48 despite i_valid=1.
- Random bytes, eta 2 and 3, random i_valid/i_ready stalls: the concatenated 256 coefficients match the golden o_coeffs.vec for the same bytes. Also check that o_coeffs is stable under stall.
- i_start with i_eta=1, then with i_eta=0 -> o_err pulse each time, o_busy stays 0.
  - i_start during RUN -> no effect on the output sequence.
- i_rst asserted at beat 20 -> next cycle all outputs 0.
  - A new i_start with eta=2 then yields a fresh, correct 64-beat polynomial.
